// File: rtl/pacc_pkg.sv
// rtl/pacc_pkg.sv - shared state type, default widths and saturation bounds for product_accumulator
// Ports: none (package). Provides pacc_state_t {ACCUM, HOLD}, PACC_ACC_W / PACC_CNT_W defaults,
//        PACC_PROD_W, and pacc_sat_max() / pacc_sat_min() to derive clamp bounds from ACC_W.
package pacc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } pacc_state_t;

    localparam int PACC_ACC_W  = 40;
    localparam int PACC_CNT_W  = 8;
    localparam int PACC_PROD_W = 32;

    // Largest positive value of an acc_w-bit signed number, zero-extended to 64 bits.
    function automatic logic [63:0] pacc_sat_max(input int acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    // Most negative acc_w-bit signed value; the low acc_w bits of the result are the pattern.
    function automatic logic [63:0] pacc_sat_min(input int acc_w);
        return ~pacc_sat_max(acc_w);
    endfunction

    localparam logic [63:0] PACC_SAT_MAX_DEF = pacc_sat_max(PACC_ACC_W);
    localparam logic [63:0] PACC_SAT_MIN_DEF = pacc_sat_min(PACC_ACC_W);

endpackage

// File: rtl/pacc_sat_add.sv
// rtl/pacc_sat_add.sv - combinational ACC_W signed adder with overflow flag and optional clamping
// Config macro: PACC_SATURATE_EN (defined: clamp on overflow; undefined: two's-complement wrap).
// Ports:
//   a   in  ACC_W : running accumulator value
//   b   in  ACC_W : sign-extended addend
//   sum out ACC_W : a + b, wrapped or clamped
//   ovf out 1     : signed overflow of the raw add
module pacc_sat_add
    import pacc_pkg::*;
#(
    parameter int ACC_W = PACC_ACC_W
)
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] raw;

    assign raw = a + b;

    // Overflow only possible when both operands share a sign and the result flips it.
    assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef PACC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(pacc_sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(pacc_sat_min(ACC_W));

    // On overflow the operand sign tells which rail was crossed.
    assign sum = !ovf ? raw : (a[ACC_W-1] ? SAT_MIN : SAT_MAX);
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - burst accumulator for signed 32-bit multiplier products
// Config macro: PACC_SATURATE_EN (passed through to pacc_sat_add).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : product beat handshake; in_prod (32, signed), in_last ends a burst
//   acc_clr               : synchronous abort of the burst in progress (ignored while holding a result)
//   out_valid/out_ready   : result handshake
//   out_sum (ACC_W)       : signed burst sum
//   out_count (CNT_W)     : beats in the burst, saturating
//   out_ovf               : some accumulate step of the burst overflowed
module product_accumulator
    import pacc_pkg::*;
#(
    parameter int ACC_W = PACC_ACC_W,
    parameter int CNT_W = PACC_CNT_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    pacc_state_t      state;
    pacc_state_t      state_nxt;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_add;
    logic [ACC_W-1:0] prod_ext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf;
    logic             step_ovf;
    logic             beat;

    assign prod_ext = ACC_W'($signed(in_prod));
    assign beat     = in_valid & in_ready;

    // Counter sticks at all-ones rather than wrapping back to zero.
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

    pacc_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (acc_add),
        .ovf (step_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (beat && in_last) state_nxt = HOLD;
            HOLD:  if (out_ready)       state_nxt = ACCUM;
        endcase
    end

    // in_ready depends only on state and acc_clr so it never loops back through in_valid.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: in_ready  = !acc_clr;
            HOLD:  out_valid = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (acc_clr) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (beat) begin
                        acc <= acc_add;
                        cnt <= cnt_inc;
                        ovf <= ovf | step_ovf;
                        if (in_last) begin
                            out_sum   <= acc_add;
                            out_count <= cnt_inc;
                            out_ovf   <= ovf | step_ovf;
                        end
                    end
                end
                HOLD: begin
                    // Result registers are left untouched so they stay stable after the handshake.
                    if (out_ready) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator (40/8 and 32/2 instances)
module tb_product_accumulator;

    localparam int WA = 40;
    localparam int CA = 8;
    localparam int WB = 32;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic          acc_clr;
    logic          out_ready;
    logic [31:0]   in_prod;

    logic          rdy_a, vld_a, ovf_a;
    logic [WA-1:0] sum_a;
    logic [CA-1:0] cnt_a;
    logic          rdy_b, vld_b, ovf_b;
    logic [WB-1:0] sum_b;
    logic [CB-1:0] cnt_b;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(WA), .CNT_W(CA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_prod(in_prod),
        .in_last(in_last), .acc_clr(acc_clr), .out_valid(vld_a), .out_ready(out_ready),
        .out_sum(sum_a), .out_count(cnt_a), .out_ovf(ovf_a)
    );

    product_accumulator #(.ACC_W(WB), .CNT_W(CB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_prod(in_prod),
        .in_last(in_last), .acc_clr(acc_clr), .out_valid(vld_b), .out_ready(out_ready),
        .out_sum(sum_b), .out_count(cnt_b), .out_ovf(ovf_b)
    );

    longint o_sum [2];
    int     o_cnt [2];
    logic   o_ovf [2];
    logic   o_vld [2];
    logic   o_rdy [2];

    always_comb begin
        o_sum[0] = longint'($signed(sum_a));
        o_sum[1] = longint'($signed(sum_b));
        o_cnt[0] = int'(cnt_a);
        o_cnt[1] = int'(cnt_b);
        o_ovf[0] = ovf_a;
        o_ovf[1] = ovf_b;
        o_vld[0] = vld_a;
        o_vld[1] = vld_b;
        o_rdy[0] = rdy_a;
        o_rdy[1] = rdy_b;
    end

    // Reference model: exact integer sums, range-checked against each instance's width.
    int     m_w    [2] = '{WA, WB};
    int     m_cmax [2] = '{(1 << CA) - 1, (1 << CB) - 1};
    longint m_acc  [2];
    int     m_cnt  [2];
    bit     m_ovf  [2];
    longint m_osum [2];
    int     m_ocnt [2];
    bit     m_oovf [2];
    bit     m_hold;
    bit     e_rdy;
    logic   s_rdy  [2];

    int total = 0;
    int bad   = 0;

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0;
            m_cnt[k] = 0;
            m_ovf[k] = 0;
        end
    endfunction

    function automatic void m_reset();
        m_clear();
        for (int k = 0; k < 2; k++) begin
            m_osum[k] = 0;
            m_ocnt[k] = 0;
            m_oovf[k] = 0;
        end
        m_hold = 0;
    endfunction

    function automatic void m_add(input longint p);
        for (int k = 0; k < 2; k++) begin
            longint s;
            longint mx;
            longint mn;
            s  = m_acc[k] + p;
            mx = (longint'(1) << (m_w[k] - 1)) - 1;
            mn = -mx - 1;
            if (s > mx) begin
                m_ovf[k] = 1;
`ifdef PACC_SATURATE_EN
                s = mx;
`else
                s = s - (longint'(1) << m_w[k]);
`endif
            end else if (s < mn) begin
                m_ovf[k] = 1;
`ifdef PACC_SATURATE_EN
                s = mn;
`else
                s = s + (longint'(1) << m_w[k]);
`endif
            end
            m_acc[k] = s;
            m_cnt[k] = (m_cnt[k] < m_cmax[k]) ? m_cnt[k] + 1 : m_cmax[k];
        end
    endfunction

    task automatic drive(input bit v, input longint p, input bit l, input bit c, input bit r);
        in_valid  = v;
        in_prod   = p[31:0];
        in_last   = l;
        acc_clr   = c;
        out_ready = r;
    endtask

    // One clock: sample in_ready mid-cycle, advance the model, return just after the edge.
    task automatic cycle();
        @(negedge clk);
        e_rdy    = !m_hold && !acc_clr;
        s_rdy[0] = o_rdy[0];
        s_rdy[1] = o_rdy[1];
        if (!m_hold) begin
            if (acc_clr) begin
                m_clear();
            end else if (in_valid) begin
                m_add(sx(in_prod));
                if (in_last) begin
                    for (int k = 0; k < 2; k++) begin
                        m_osum[k] = m_acc[k];
                        m_ocnt[k] = m_cnt[k];
                        m_oovf[k] = m_ovf[k];
                    end
                    m_hold = 1;
                end
            end
        end else if (out_ready) begin
            m_clear();
            m_hold = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_sum[k] !== 0 || o_cnt[k] !== 0 || o_ovf[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_out[%0d]: got sum=%0d cnt=%0d ovf=%b want 0/0/0", k, o_sum[k], o_cnt[k], o_ovf[k]);
            end
            total++;
            if (o_rdy[k] !== 1'b1 || o_vld[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_hs[%0d]: got rdy=%b vld=%b want 1/0", k, o_rdy[k], o_vld[k]);
            end
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic_burst();
        drive(1, 6, 0, 0, 1);          cycle();
        drive(1, -20, 0, 0, 1);        cycle();
        drive(1, 1073741824, 1, 0, 1); cycle();
        total++;
        if (vld_a !== 1'b1) begin bad++; $display("FAIL basic_vld: got %b want 1", vld_a); end
        total++;
        if (o_sum[0] !== 1073741810) begin bad++; $display("FAIL basic_sum: got %0d want 1073741810", o_sum[0]); end
        total++;
        if (cnt_a !== 8'd3) begin bad++; $display("FAIL basic_cnt: got %0d want 3", cnt_a); end
        total++;
        if (ovf_a !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", ovf_a); end
        total++;
        if (o_sum[1] !== 1073741810 || cnt_b !== 2'd3) begin
            bad++;
            $display("FAIL basic_b: got sum=%0d cnt=%0d want 1073741810/3", o_sum[1], cnt_b);
        end
        drive(0, 0, 0, 0, 1); cycle();
        total++;
        if (vld_a !== 1'b0 || rdy_a !== 1'b1) begin
            bad++;
            $display("FAIL basic_pulse: got vld=%b rdy=%b want 0/1", vld_a, rdy_a);
        end
    endtask

    task automatic test_single_beat();
        drive(1, -1073709056, 1, 0, 1); cycle();
        total++;
        if (o_sum[0] !== -1073709056 || cnt_a !== 8'd1) begin
            bad++;
            $display("FAIL single_a: got sum=%0d cnt=%0d want -1073709056/1", o_sum[0], cnt_a);
        end
        total++;
        if (o_sum[1] !== -1073709056 || cnt_b !== 2'd1) begin
            bad++;
            $display("FAIL single_b: got sum=%0d cnt=%0d want -1073709056/1", o_sum[1], cnt_b);
        end
        drive(0, 0, 0, 0, 1); cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] p1, p2, p3;
        longint      exp_sum;
        p1 = $urandom;
        p2 = $urandom;
        p3 = $urandom;
        exp_sum = sx(p1) + sx(p2);
        drive(1, sx(p1), 0, 0, 0); cycle();
        drive(1, sx(p2), 1, 0, 0); cycle();
        total++;
        if (o_sum[0] !== exp_sum || cnt_a !== 8'd2) begin
            bad++;
            $display("FAIL bp_result: got sum=%0d cnt=%0d want %0d/2", o_sum[0], cnt_a, exp_sum);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, longint'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
            cycle();
            total++;
            if (s_rdy[0] !== 1'b0 || s_rdy[1] !== 1'b0) begin
                bad++;
                $display("FAIL bp_in_ready[%0d]: got %b%b want 00", i, s_rdy[0], s_rdy[1]);
            end
            total++;
            if (vld_a !== 1'b1 || o_sum[0] !== exp_sum || cnt_a !== 8'd2) begin
                bad++;
                $display("FAIL bp_stable[%0d]: got vld=%b sum=%0d cnt=%0d want 1/%0d/2", i, vld_a, o_sum[0], cnt_a, exp_sum);
            end
        end
        drive(1, 55, 1, 0, 1); cycle();
        total++;
        if (s_rdy[0] !== 1'b0) begin bad++; $display("FAIL bp_release_rdy: got %b want 0", s_rdy[0]); end
        drive(1, sx(p3), 1, 0, 1); cycle();
        total++;
        if (o_sum[0] !== sx(p3) || cnt_a !== 8'd1) begin
            bad++;
            $display("FAIL bp_restart: got sum=%0d cnt=%0d want %0d/1", o_sum[0], cnt_a, sx(p3));
        end
        drive(0, 0, 0, 0, 1); cycle();
    endtask

    task automatic test_overflow();
        drive(1, 1073741824, 0, 0, 1); cycle();
        drive(1, 1073741824, 1, 0, 1); cycle();
`ifdef PACC_SATURATE_EN
        total++;
        if (o_sum[1] !== 64'sd2147483647 || ovf_b !== 1'b1) begin
            bad++;
            $display("FAIL ovf_b: got sum=%0d ovf=%b want 2147483647/1", o_sum[1], ovf_b);
        end
`else
        total++;
        if (o_sum[1] !== -64'sd2147483648 || ovf_b !== 1'b1) begin
            bad++;
            $display("FAIL ovf_b: got sum=%0d ovf=%b want -2147483648/1", o_sum[1], ovf_b);
        end
`endif
        total++;
        if (o_sum[0] !== 64'sd2147483648 || ovf_a !== 1'b0) begin
            bad++;
            $display("FAIL ovf_a: got sum=%0d ovf=%b want 2147483648/0", o_sum[0], ovf_a);
        end
        drive(0, 0, 0, 0, 1); cycle();
    endtask

    task automatic test_abort();
        drive(1, 100, 0, 0, 1); cycle();
        drive(1, 200, 0, 0, 1); cycle();
        drive(1, 50, 0, 1, 1);  cycle();
        total++;
        if (s_rdy[0] !== 1'b0 || s_rdy[1] !== 1'b0) begin
            bad++;
            $display("FAIL abort_rdy: got %b%b want 00", s_rdy[0], s_rdy[1]);
        end
        drive(1, 7, 1, 0, 1); cycle();
        total++;
        if (o_sum[0] !== 7 || cnt_a !== 8'd1 || o_sum[1] !== 7 || cnt_b !== 2'd1) begin
            bad++;
            $display("FAIL abort_result: got sum=%0d/%0d cnt=%0d/%0d want 7/7 1/1", o_sum[0], o_sum[1], cnt_a, cnt_b);
        end
        drive(0, 0, 0, 0, 1); cycle();
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, (i == 5), 0, 1);
            cycle();
        end
        total++;
        if (cnt_b !== 2'd3 || o_sum[1] !== 6) begin
            bad++;
            $display("FAIL cnt_sat_b: got cnt=%0d sum=%0d want 3/6", cnt_b, o_sum[1]);
        end
        total++;
        if (cnt_a !== 8'd6 || o_sum[0] !== 6) begin
            bad++;
            $display("FAIL cnt_a: got cnt=%0d sum=%0d want 6/6", cnt_a, o_sum[0]);
        end
        drive(0, 0, 0, 0, 1); cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), sx($urandom), ($urandom_range(4) == 0),
                  ($urandom_range(19) == 0), ($urandom_range(4) < 3));
            cycle();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (s_rdy[k] !== e_rdy || o_vld[k] !== m_hold) begin
                    bad++;
                    $display("FAIL rnd_hs[%0d] i=%0d: got rdy=%b vld=%b want %b/%b", k, i, s_rdy[k], o_vld[k], e_rdy, m_hold);
                end
                total++;
                if (o_sum[k] !== m_osum[k] || o_cnt[k] !== m_ocnt[k] || o_ovf[k] !== m_oovf[k]) begin
                    bad++;
                    $display("FAIL rnd_out[%0d] i=%0d: got %0d/%0d/%b want %0d/%0d/%b", k, i,
                             o_sum[k], o_cnt[k], o_ovf[k], m_osum[k], m_ocnt[k], m_oovf[k]);
                end
            end
        end
        drive(0, 0, 0, 0, 1);
        repeat (2) cycle();
    endtask

    task automatic test_reset_mid();
        drive(1, 12345, 1, 0, 1); cycle();
        drive(1, 2, 0, 0, 1);     cycle();
        drive(1, 3, 0, 0, 1);     cycle();
        total++;
        if (o_sum[0] !== 12345) begin bad++; $display("FAIL rstmid_pre: got %0d want 12345", o_sum[0]); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_sum[k] !== 0 || o_cnt[k] !== 0 || o_ovf[k] !== 1'b0 || o_vld[k] !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_async[%0d]: got sum=%0d cnt=%0d ovf=%b vld=%b want zeros", k, o_sum[k], o_cnt[k], o_ovf[k], o_vld[k]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 9, 1, 0, 1); cycle();
        total++;
        if (o_sum[0] !== 9 || cnt_a !== 8'd1) begin
            bad++;
            $display("FAIL rstmid_after: got sum=%0d cnt=%0d want 9/1", o_sum[0], cnt_a);
        end
        drive(0, 0, 0, 0, 1); cycle();
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_single_beat();
        test_backpressure();
        test_overflow();
        test_abort();
        test_count_sat();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
